reg_file_mp: RTL
================

# reg_file_mp

Parametrised integer register file for the core pipeline. It has two combinational read ports and two synchronous write ports. Same-cycle write-to-read bypass is built in. A sequential clear engine zeroes the whole array after reset or on request. It replaces the fixed 32x32, single-write register file and sits between decode (reads) and writeback/load-return (writes).

## Interface
- XLEN, 32: data width in bits, ≥8.
- NREG, 32: number of architectural registers, power of two, ≥4. Address width AW = clog2(NREG).
- BYPASS, 1: 1 = same-cycle write data is forwarded to the read ports; 0 = a read returns the array contents only.

- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr_req  in  1  one-cycle request to re-zero the array; honoured only while ready=1.
- ready  out  1  1 = array initialised and writes accepted.
- raddr_rs1  in  AW  read address, port 1.
- raddr_rs2  in  AW  read address, port 2.
- rdata_rs1  out  XLEN  read data, port 1 (combinational).
- rdata_rs2  out  XLEN  read data, port 2 (combinational).
- we0  in  1  write enable, port 0 (writeback).
- waddr0  in  AW  write address, port 0.
- wdata0  in  XLEN  write data, port 0.
- we1  in  1  write enable, port 1 (load return).
- waddr1  in  AW  write address, port 1.
- wdata1  in  XLEN  write data, port 1.

## Operation
- FSM states: CLEAR and READY.
  - rst=1 → state=CLEAR, cnt=0, ready=0. Nothing is written while rst=1.
  - CLEAR, rst=0: each cycle writes reg[cnt] <= 0 and increments cnt. In the cycle where cnt==NREG-1, that register is cleared, the next state is READY and cnt wraps to 0.
  - READY with clr_req=1 → next state CLEAR, cnt=0. Writes presented in that same cycle are still performed.
  - clr_req is ignored in CLEAR.
- Register 0 is hard zero.
  - Writes to address 0 are dropped on both ports.
  - Reads of address 0 always return 0.
- Effective write enables:
  - ew0 = we0 & ready & (waddr0≠0).
  - ew1 = we1 & ready & (waddr1≠0).
  - we0/we1 in CLEAR are discarded, not queued.
- Write collision (ew0 & ew1 & waddr0==waddr1): port 1 wins. wdata1 is stored and wdata0 is lost.
- Writes to different addresses in the same cycle both take effect.
- Read data, per port, in priority order:
  1. raddr==0 → 0.
  2. ready=0 → 0.
  3. BYPASS=1 & ew1 & waddr1==raddr → wdata1.
  4. BYPASS=1 & ew0 & waddr0==raddr → wdata0.
  5. Otherwise → reg[raddr].
- Both read ports may use the same address at the same time. They return identical data.
- Address arithmetic: cnt is AW bits wide and wraps modulo NREG. There is no out-of-range address, because NREG is a power of two.

## Timing
- Reset values: ready=0, rdata_rs1=0, rdata_rs2=0, state=CLEAR, cnt=0. Array contents are undefined until the clear completes.
- Clear latency:
  - ready rises exactly NREG cycles after the first rising edge with rst=0.
  - After clr_req, ready falls on the next edge and is low for exactly NREG cycles.
- Reset asserted mid-clear: cnt returns to 0 and the full NREG-cycle clear restarts after rst deasserts.
- Read latency is 0 cycles (combinational from raddr, array state and the write ports).
- Write latency: data written at edge N is returned from the array for reads in cycle N+1.
  - With BYPASS=1 the data is also visible in cycle N, before the edge.
  - With BYPASS=0 the read in cycle N returns the old value.
- ready is the only indication of accepted writes. Upstream must hold off writes while ready=0.

## Test plan
- Reset and clear, NREG=32: hold rst for 3 cycles, then release. ready=0 for exactly 32 cycles, then 1. Every register 0–31 then reads 0x00000000.
- Basic write/read: write 0xDEADBEEF to r5 via port 0. Next cycle, raddr_rs1=5 and raddr_rs2=5 both return 0xDEADBEEF. A write of 0x1234 to r0 is dropped; r0 still reads 0.
- Collision and dual write:
  - Same cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22 → r7 reads 0x22.
  - Next cycle, port 0 writes r3=0xA and port 1 writes r4=0xB → both registers updated.
- Bypass: with BYPASS=1, drive we1, waddr1=9, wdata1=0x55 and raddr_rs2=9 in the same cycle → rdata_rs2=0x55 that cycle. Repeat with BYPASS=0 → the old r9 value is returned that cycle and 0x55 the next cycle.
- clr_req mid-operation:
  - Fill r1–r31 with nonzero data, then pulse clr_req with we0 writing r2=0x77. The write lands, ready falls for 32 cycles, and all registers read 0 afterwards.
  - we0 asserted during the clear is discarded.
- Reset during clear: assert rst when cnt=10, for 1 cycle. ready stays low for a full 32 cycles after release.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear request/ready, two read ports and two write ports.
// Master is the pipeline side; slave is the register file.
interface reg_file_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  logic            clr_req;
  logic            ready;
  logic [AW-1:0]   raddr_rs1;
  logic [AW-1:0]   raddr_rs2;
  logic [XLEN-1:0] rdata_rs1;
  logic [XLEN-1:0] rdata_rs2;
  logic            we0;
  logic [AW-1:0]   waddr0;
  logic [XLEN-1:0] wdata0;
  logic            we1;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata1;

  modport master (
    output clr_req, raddr_rs1, raddr_rs2, we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  ready, rdata_rs1, rdata_rs2
  );

  modport slave (
    input  clr_req, raddr_rs1, raddr_rs2, we0, waddr0, wdata0, we1, waddr1, wdata1,
    output ready, rdata_rs1, rdata_rs2
  );
endinterface

// File: rtl/reg_file_mp.sv
// Integer register file: two combinational read ports, two synchronous write ports,
// optional same-cycle bypass, r0 hard-wired to zero, sequential clear after reset or on request.
module reg_file_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [AW-1:0]   w_cnt_nxt;
  logic [XLEN-1:0] r_mem [NREG];

  logic            w_ready;
  logic            w_ew0;
  logic            w_ew1;
  logic [AW-1:0]   w_raddr [2];
  logic [XLEN-1:0] w_rdata [2];

  assign w_ready = (r_state == ST_READY);
  assign w_ew0   = bus.we0 & w_ready & (bus.waddr0 != '0);
  assign w_ew1   = bus.we1 & w_ready & (bus.waddr1 != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == '1) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        if (bus.clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: the array has no reset; the clear engine zeroes it one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_cnt] <= '0;
      end else begin
        if (w_ew0) r_mem[bus.waddr0] <= bus.wdata0;
        // Port 1 is assigned last, so it wins an address collision.
        if (w_ew1) r_mem[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  assign w_raddr[0] = bus.raddr_rs1;
  assign w_raddr[1] = bus.raddr_rs2;

  // Later assignments override earlier ones, so the highest-priority source is applied last.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_mem[w_raddr[p]];
      if (BYPASS != 0 && w_ew0 && bus.waddr0 == w_raddr[p]) w_rdata[p] = bus.wdata0;
      if (BYPASS != 0 && w_ew1 && bus.waddr1 == w_raddr[p]) w_rdata[p] = bus.wdata1;
      if (w_raddr[p] == '0 || !w_ready) w_rdata[p] = '0;
    end
  end

  assign bus.ready     = w_ready;
  assign bus.rdata_rs1 = w_rdata[0];
  assign bus.rdata_rs2 = w_rdata[1];
endmodule
